fetch_stage: RTL and testbench
==============================

// Module: fetch_stage
// PURPOSE
//  IF stage of the 5-stage pipeline. Owns the PC, drives the instruction-memory address,
//  captures the returned word into the IF/ID register. Handles stall, branch redirect
//  (with flush) and halt. Sits directly upstream of decode, alongside the read-only
//  instruction memory (combinational read, T_rd = 20 ns).
// PARAMETERS
//  START_PC   64'h0   PC value loaded on reset
//  PC_INCR    4       sequential PC increment, in bytes
//  CNT_W      32      width of the fetched-instruction counter
// PORTS
//  CLK            in   1    rising-edge clock
//  Reset          in   1    synchronous, active-high reset
//  Stall          in   1    hazard unit: hold PC and IF/ID
//  Redirect       in   1    taken branch/jump resolved downstream
//  RedirectPC     in   64   target for Redirect
//  Halt           in   1    stop fetching at the next edge
//  InstrData      in   32   word from instruction memory
//  InstrAddr      out  64   address to instruction memory (= PC)
//  IfIdInstr      out  32   IF/ID instruction
//  IfIdPC         out  64   IF/ID PC of that instruction
//  IfIdValid      out  1    IF/ID holds a real instruction
//  Halted         out  1    FSM is in HALTED
//  FetchCount     out  CNT_W  count of instructions latched valid, saturating
// BEHAVIOUR
//  - InstrAddr = PC, combinational. InstrData sampled at the next CLK edge; period > T_rd.
//  - Reset (sync): PC<=START_PC, IfIdInstr<=32'h0, IfIdPC<=0, IfIdValid<=0, FSM<=RUN,
//    FetchCount<=0. Reset mid-operation discards everything, incl. a pending Redirect.
//  - FSM states: RUN, HALTED. RUN->HALTED when Halt=1 and Redirect=0. HALTED->RUN only
//    on Redirect. Halted=1 iff state==HALTED.
//  - Per edge, priority Reset > Redirect > Stall > Halt > normal:
//    Redirect: PC<=RedirectPC with [1:0] forced to 0; IF/ID flushed (Instr=0, Valid=0);
//      wins over a simultaneous Stall (flushed IF/ID is never held).
//    Stall: PC, IfIdInstr, IfIdPC, IfIdValid all hold; FetchCount holds.
//    Halt (RUN, no Redirect/Stall): PC holds; IF/ID loads bubble (Instr=0, Valid=0).
//    HALTED, no Redirect: PC holds, IF/ID bubble every cycle, Stall ignored.
//    Normal RUN: IfIdInstr<=InstrData, IfIdPC<=PC, IfIdValid<=1, PC<=PC+PC_INCR.
//  - PC+PC_INCR wraps modulo 2^64; no wrap detection.
//  - FetchCount += 1 on every edge where IfIdValid is loaded with 1; saturates at all-ones.
//  - A bubble is 32'h0. Decode treats it as NOP, and IfIdValid=0 marks it as not counted.
//  - Latency: word at PC reaches IfIdInstr one edge after PC is presented.
// STRUCTURE
//  - Shared package pipeline_pkg: NOP_INSTR=32'h0, state enum {RUN,HALTED},
//    and the IF/ID record (instr, pc, valid), which decode reuses.
//  - Sub-module fetch_pc_reg: PC register with next-PC mux (reset/redirect/hold/incr).
//  - The IF/ID register, FSM and counter live in fetch_stage itself.
// TESTING (memory model preloaded: 0x0 MOVZ X0,#10=32'hD2800140, 0x10 ADD X4,X0,X1=32'h8B010004)
//  1 Reset 2 cycles, release -> InstrAddr=0, IfIdValid=0, FetchCount=0; next edge
//    IfIdInstr=32'hD2800140, IfIdPC=0, InstrAddr=4.
//  2 Free-run 5 edges -> IfIdInstr=32'h8B010004, IfIdPC=0x10, FetchCount=5, InstrAddr=0x14.
//  3 Stall 3 cycles at PC=8 -> InstrAddr stays 8, IF/ID unchanged, FetchCount unchanged;
//    release -> IfIdPC=8 next edge.
//  4 Redirect with RedirectPC=0x13 together with Stall -> PC=0x10, IfIdValid=0, then
//    IfIdInstr=32'h8B010004.
//  5 Halt at PC=0xC -> Halted=1, PC frozen at 0xC, IfIdValid=0 for 4 cycles;
//    Redirect to 0 -> Halted=0, fetch resumes at 0.
//  6 Reset asserted mid-stream at PC=0x18 -> PC=0, IF/ID cleared, FetchCount=0 next edge.
//    Wrap: Reset with START_PC=64'hFFFF_FFFF_FFFF_FFFC, then run -> PC=0 after one edge.

Source files
------------

// File: rtl/pipeline_pkg.sv
// Types and constants shared by the front-end pipeline stages.
// Decode reuses the IF/ID record defined here.
package pipeline_pkg;

    localparam logic [31:0] NOP_INSTR = 32'h0;

    typedef enum logic {
        RUN    = 1'b0,
        HALTED = 1'b1
    } fetch_state_e;

    typedef struct packed {
        logic [31:0] instr;
        logic [63:0] pc;
        logic        valid;
    } ifid_t;

endpackage

// File: rtl/fetch_pc_reg.sv
// Program counter register with its next-PC selection.
// A redirect target is forced onto a 4-byte boundary.
module fetch_pc_reg #(
    parameter logic [63:0] START_PC = 64'h0,
    parameter int unsigned PC_INCR  = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        redirect,
    input  logic [63:0] redirect_pc,
    input  logic        hold,
    output logic [63:0] pc
);

    logic [63:0] pc_d;
    logic [63:0] pc_q;

    always_comb begin
        pc_d = pc_q;
        if (redirect) begin
            pc_d = {redirect_pc[63:2], 2'b00};
        end else if (!hold) begin
            pc_d = pc_q + 64'(PC_INCR);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            pc_q <= START_PC;
        end else begin
            pc_q <= pc_d;
        end
    end

    assign pc = pc_q;

endmodule

// File: rtl/fetch_stage.sv
// Instruction fetch stage: owns the PC, fills the IF/ID register and
// tracks the RUN/HALTED state plus a saturating fetched-instruction count.
module fetch_stage
    import pipeline_pkg::*;
#(
    parameter logic [63:0] START_PC = 64'h0,
    parameter int unsigned PC_INCR  = 4,
    parameter int          CNT_W    = 32
) (
    input  logic             CLK,
    input  logic             Reset,
    input  logic             Stall,
    input  logic             Redirect,
    input  logic [63:0]      RedirectPC,
    input  logic             Halt,
    input  logic [31:0]      InstrData,
    output logic [63:0]      InstrAddr,
    output logic [31:0]      IfIdInstr,
    output logic [63:0]      IfIdPC,
    output logic             IfIdValid,
    output logic             Halted,
    output logic [CNT_W-1:0] FetchCount
);

    fetch_state_e     state_d, state_q;
    ifid_t            ifid_d, ifid_q;
    logic [CNT_W-1:0] count_d, count_q;
    logic [63:0]      pc;
    logic             advance;

    // The PC only moves on a normal fetch or a redirect.
    assign advance = (state_q == RUN) && !Stall && !Halt;

    fetch_pc_reg #(
        .START_PC (START_PC),
        .PC_INCR  (PC_INCR)
    ) u_pc_reg (
        .clk         (CLK),
        .rst         (Reset),
        .redirect    (Redirect),
        .redirect_pc (RedirectPC),
        .hold        (!advance),
        .pc          (pc)
    );

    always_comb begin
        state_d = state_q;
        ifid_d  = ifid_q;
        count_d = count_q;
        if (Redirect) begin
            state_d      = RUN;
            ifid_d.instr = NOP_INSTR;
            ifid_d.valid = 1'b0;
        end else begin
            case (state_q)
                RUN: begin
                    if (Halt) begin
                        state_d = HALTED;
                    end
                    if (Stall) begin
                        ifid_d = ifid_q;
                    end else if (Halt) begin
                        ifid_d.instr = NOP_INSTR;
                        ifid_d.valid = 1'b0;
                    end else begin
                        ifid_d.instr = InstrData;
                        ifid_d.pc    = pc;
                        ifid_d.valid = 1'b1;
                        if (count_q != '1) begin
                            count_d = count_q + 1'b1;
                        end
                    end
                end
                HALTED: begin
                    ifid_d.instr = NOP_INSTR;
                    ifid_d.valid = 1'b0;
                end
                default: begin
                    state_d = RUN;
                end
            endcase
        end
    end

    always_ff @(posedge CLK) begin
        if (Reset) begin
            state_q <= RUN;
            ifid_q  <= '{instr: NOP_INSTR, pc: 64'h0, valid: 1'b0};
            count_q <= '0;
        end else begin
            state_q <= state_d;
            ifid_q  <= ifid_d;
            count_q <= count_d;
        end
    end

    assign InstrAddr  = pc;
    assign IfIdInstr  = ifid_q.instr;
    assign IfIdPC     = ifid_q.pc;
    assign IfIdValid  = ifid_q.valid;
    assign Halted     = (state_q == HALTED);
    assign FetchCount = count_q;

endmodule

// File: tb/tb_fetch_stage.sv
// Bench for fetch_stage: directed scenarios plus randomized control traffic
// compared against a behavioural model of the fetch rules.
module tb_fetch_stage;

    logic        CLK = 1'b0;
    logic        Reset = 1'b0, Stall = 1'b0, Redirect = 1'b0, Halt = 1'b0;
    logic [63:0] RedirectPC = 64'h0;
    logic [31:0] InstrData;
    logic [63:0] InstrAddr, IfIdPC;
    logic [31:0] IfIdInstr;
    logic        IfIdValid, Halted;
    logic [31:0] FetchCount;

    logic        w_reset = 1'b0;
    logic [31:0] w_data, w_instr;
    logic [63:0] w_addr, w_ifpc;
    logic        w_valid, w_halted;
    logic [2:0]  w_count;

    int n_checks = 0;
    int n_pass   = 0;

    // behavioural model state
    logic [63:0] m_pc, m_ifpc;
    logic [31:0] m_instr;
    logic        m_valid, m_halted;
    longint      m_cnt;

    always #20 CLK = ~CLK;

    function automatic logic [31:0] mem(input logic [63:0] a);
        if (a == 64'h0)  return 32'hD2800140;
        if (a == 64'h10) return 32'h8B010004;
        return (a[31:0] * 32'h9E3779B1) ^ 32'h5A5A0001;
    endfunction

    assign InstrData = mem(InstrAddr);
    assign w_data    = mem(w_addr);

    fetch_stage u_dut (
        .CLK (CLK), .Reset (Reset), .Stall (Stall), .Redirect (Redirect),
        .RedirectPC (RedirectPC), .Halt (Halt), .InstrData (InstrData),
        .InstrAddr (InstrAddr), .IfIdInstr (IfIdInstr), .IfIdPC (IfIdPC),
        .IfIdValid (IfIdValid), .Halted (Halted), .FetchCount (FetchCount)
    );

    fetch_stage #(.START_PC (64'hFFFF_FFFF_FFFF_FFFC), .CNT_W (3)) u_wrap (
        .CLK (CLK), .Reset (w_reset), .Stall (1'b0), .Redirect (1'b0),
        .RedirectPC (64'h0), .Halt (1'b0), .InstrData (w_data),
        .InstrAddr (w_addr), .IfIdInstr (w_instr), .IfIdPC (w_ifpc),
        .IfIdValid (w_valid), .Halted (w_halted), .FetchCount (w_count)
    );

    // One clock edge of the fetch rules, seen from outside the block.
    task automatic model_step(input bit rst, stall, redir, input logic [63:0] tgt, input bit halt);
        if (rst) begin
            m_pc = 64'h0; m_instr = 32'h0; m_ifpc = 64'h0; m_valid = 0; m_halted = 0; m_cnt = 0;
        end else if (redir) begin
            m_pc = {tgt[63:2], 2'b00}; m_instr = 32'h0; m_valid = 0; m_halted = 0;
        end else if (m_halted) begin
            m_instr = 32'h0; m_valid = 0;
        end else if (stall) begin
            if (halt) m_halted = 1;
        end else if (halt) begin
            m_instr = 32'h0; m_valid = 0; m_halted = 1;
        end else begin
            m_instr = mem(m_pc); m_ifpc = m_pc; m_valid = 1;
            m_pc = m_pc + 64'd4;
            if (m_cnt < 64'hFFFF_FFFF) m_cnt++;
        end
    endtask

    task automatic tick(input bit rst, stall, redir, input logic [63:0] tgt, input bit halt);
        Reset = rst; Stall = stall; Redirect = redir; RedirectPC = tgt; Halt = halt;
        @(posedge CLK);
        model_step(rst, stall, redir, tgt, halt);
        #1;
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) tick(0, 0, 0, 64'h0, 0);
    endtask

    task automatic test_reset;
        tick(1, 0, 0, 64'h0, 0);
        tick(1, 0, 0, 64'h0, 0);
        n_checks++; if (InstrAddr !== 64'h0) $display("FAIL reset_addr got %h exp 0", InstrAddr); else n_pass++;
        n_checks++; if (IfIdValid !== 1'b0) $display("FAIL reset_valid got %b exp 0", IfIdValid); else n_pass++;
        n_checks++; if (FetchCount !== 32'h0) $display("FAIL reset_count got %0d exp 0", FetchCount); else n_pass++;
        n_checks++; if (IfIdInstr !== 32'h0 || Halted !== 1'b0) $display("FAIL reset_ifid got %h/%b exp 0/0", IfIdInstr, Halted); else n_pass++;
        run(1);
        n_checks++; if (IfIdInstr !== 32'hD2800140) $display("FAIL first_instr got %h exp d2800140", IfIdInstr); else n_pass++;
        n_checks++; if (IfIdPC !== 64'h0 || InstrAddr !== 64'h4) $display("FAIL first_pc got %h/%h exp 0/4", IfIdPC, InstrAddr); else n_pass++;
    endtask

    task automatic test_free_run;
        run(4);
        n_checks++; if (IfIdInstr !== 32'h8B010004) $display("FAIL run_instr got %h exp 8b010004", IfIdInstr); else n_pass++;
        n_checks++; if (IfIdPC !== 64'h10) $display("FAIL run_pc got %h exp 10", IfIdPC); else n_pass++;
        n_checks++; if (FetchCount !== 32'd5) $display("FAIL run_count got %0d exp 5", FetchCount); else n_pass++;
        n_checks++; if (InstrAddr !== 64'h14) $display("FAIL run_addr got %h exp 14", InstrAddr); else n_pass++;
    endtask

    task automatic test_stall;
        tick(1, 0, 0, 64'h0, 0);
        run(2);
        for (int i = 0; i < 3; i++) begin
            tick(0, 1, 0, 64'h0, 0);
            n_checks++;
            if (InstrAddr !== 64'h8 || IfIdPC !== 64'h4 || IfIdInstr !== mem(64'h4) || IfIdValid !== 1'b1 || FetchCount !== 32'd2)
                $display("FAIL stall_hold got addr=%h pc=%h cnt=%0d exp addr=8 pc=4 cnt=2", InstrAddr, IfIdPC, FetchCount);
            else n_pass++;
        end
        run(1);
        n_checks++; if (IfIdPC !== 64'h8 || FetchCount !== 32'd3) $display("FAIL stall_release got pc=%h cnt=%0d exp 8/3", IfIdPC, FetchCount); else n_pass++;
    endtask

    task automatic test_redirect_stall;
        tick(0, 1, 1, 64'h13, 0);
        n_checks++; if (InstrAddr !== 64'h10) $display("FAIL redir_pc got %h exp 10", InstrAddr); else n_pass++;
        n_checks++; if (IfIdValid !== 1'b0 || IfIdInstr !== 32'h0) $display("FAIL redir_flush got %b/%h exp 0/0", IfIdValid, IfIdInstr); else n_pass++;
        run(1);
        n_checks++; if (IfIdInstr !== 32'h8B010004 || IfIdPC !== 64'h10) $display("FAIL redir_fetch got %h@%h exp 8b010004@10", IfIdInstr, IfIdPC); else n_pass++;
    endtask

    task automatic test_halt;
        tick(1, 0, 0, 64'h0, 0);
        run(3);
        tick(0, 0, 0, 64'h0, 1);
        for (int i = 0; i < 4; i++) begin
            n_checks++;
            if (Halted !== 1'b1 || InstrAddr !== 64'hC || IfIdValid !== 1'b0 || FetchCount !== 32'd3)
                $display("FAIL halt_hold got h=%b addr=%h v=%b cnt=%0d exp 1/c/0/3", Halted, InstrAddr, IfIdValid, FetchCount);
            else n_pass++;
            tick(0, i == 1, 0, 64'h0, i == 2);
        end
        tick(0, 0, 1, 64'h0, 0);
        n_checks++; if (Halted !== 1'b0 || InstrAddr !== 64'h0) $display("FAIL halt_redir got h=%b addr=%h exp 0/0", Halted, InstrAddr); else n_pass++;
        run(1);
        n_checks++; if (IfIdInstr !== 32'hD2800140 || IfIdPC !== 64'h0 || IfIdValid !== 1'b1) $display("FAIL halt_resume got %h@%h exp d2800140@0", IfIdInstr, IfIdPC); else n_pass++;
    endtask

    task automatic test_reset_midstream;
        tick(1, 0, 0, 64'h0, 0);
        run(6);
        n_checks++; if (InstrAddr !== 64'h18) $display("FAIL mid_pre got %h exp 18", InstrAddr); else n_pass++;
        tick(1, 0, 1, 64'h40, 0);
        n_checks++;
        if (InstrAddr !== 64'h0 || IfIdValid !== 1'b0 || IfIdInstr !== 32'h0 || IfIdPC !== 64'h0 || FetchCount !== 32'h0)
            $display("FAIL mid_reset got addr=%h v=%b i=%h pc=%h cnt=%0d exp all 0", InstrAddr, IfIdValid, IfIdInstr, IfIdPC, FetchCount);
        else n_pass++;
    endtask

    task automatic test_wrap_saturate;
        w_reset = 1'b1;
        @(posedge CLK); @(posedge CLK); #1;
        w_reset = 1'b0;
        n_checks++; if (w_addr !== 64'hFFFF_FFFF_FFFF_FFFC) $display("FAIL wrap_start got %h exp fffffffffffffffc", w_addr); else n_pass++;
        @(posedge CLK); #1;
        n_checks++; if (w_addr !== 64'h0 || w_ifpc !== 64'hFFFF_FFFF_FFFF_FFFC || w_valid !== 1'b1) $display("FAIL wrap_pc got %h/%h exp 0/fffffffffffffffc", w_addr, w_ifpc); else n_pass++;
        for (int i = 0; i < 8; i++) begin @(posedge CLK); #1; end
        n_checks++; if (w_count !== 3'd7 || w_addr !== 64'h20) $display("FAIL sat_count got %0d addr=%h exp 7/20", w_count, w_addr); else n_pass++;
        n_checks++; if (w_halted !== 1'b0 || w_instr !== mem(64'h1C)) $display("FAIL sat_instr got %h exp %h", w_instr, mem(64'h1C)); else n_pass++;
    endtask

    task automatic test_random;
        int errs;
        errs = 0;
        tick(1, 0, 0, 64'h0, 0);
        for (int i = 0; i < 400; i++) begin
            tick($urandom_range(99) < 2, $urandom_range(99) < 25, $urandom_range(99) < 10,
                 {32'h0, 24'h0, 8'($urandom)}, $urandom_range(99) < 8);
            n_checks++;
            if (InstrAddr !== m_pc || IfIdValid !== m_valid || IfIdInstr !== m_instr || Halted !== m_halted ||
                FetchCount !== m_cnt[31:0] || (m_valid && IfIdPC !== m_ifpc)) begin
                if (errs < 10)
                    $display("FAIL rand_%0d got addr=%h v=%b i=%h h=%b cnt=%0d pc=%h exp addr=%h v=%b i=%h h=%b cnt=%0d pc=%h",
                             i, InstrAddr, IfIdValid, IfIdInstr, Halted, FetchCount, IfIdPC,
                             m_pc, m_valid, m_instr, m_halted, m_cnt, m_ifpc);
                errs++;
            end else n_pass++;
        end
    endtask

    initial begin
        test_reset();
        test_free_run();
        test_stall();
        test_redirect_stall();
        test_halt();
        test_reset_midstream();
        test_wrap_saturate();
        test_random();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
